vlane_shift_arbiter: RTL and testbench
======================================

Name: vlane_shift_arbiter

Overview:
- Shares one two-stage pipelined vector-lane barrel shifter among NUM_REQ requesters, for example the lane ALU path and the vector-permute/scalar-broadcast path.
- Arbitrates round-robin and drives the shifter's operand, shift-amount and op inputs.
- Tracks in-flight operations through the fixed shifter latency.
- Buffers results in a credit-protected FIFO so downstream backpressure never drops a shifter result.

Parameters:
WIDTH, 32, data width of the shifted operand
LOG2WIDTH, 5, shift-amount width
NUM_REQ, 2, number of requesters
LOG2NUMREQ, 1, requester-id width
TAGW, 4, opaque tag width carried with each operation
LATENCY, 2, shifter cycles from issue to result
FIFO_DEPTH, 4, result FIFO entries (must be >= LATENCY)
LOG2FIFO, 2, FIFO pointer width

Ports:
clk  in  1  clock
reset  in  1  reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  one-hot grant; operation accepted when valid&ready
req_opB  in  NUM_REQ*WIDTH  operand, requester i at [i*WIDTH +: WIDTH]
req_sa  in  NUM_REQ*LOG2WIDTH  shift amount
req_op  in  NUM_REQ*2  op[1]=sign_ext, op[0]=direction (00 SLL, 01 SRL, 11 SRA)
req_tag  in  NUM_REQ*TAGW  tag returned with the result
sh_opB  out  WIDTH  to shifter operand
sh_sa  out  LOG2WIDTH  to shifter shift amount
sh_op  out  2  to shifter op
sh_result  in  WIDTH  from shifter, valid LATENCY cycles after issue
rsp_valid  out  1  result available at FIFO head
rsp_ready  in  1  consumer accepts head
rsp_result  out  WIDTH  shifted result
rsp_id  out  LOG2NUMREQ  originating requester
rsp_tag  out  TAGW  originating tag
busy  out  1  any op in flight or FIFO non-empty

Behaviour:
Clock and reset:
- One clock, clk.
- reset is synchronous and active-high.

Reset:
- On reset: in-flight valid pipe cleared, FIFO empty, round-robin pointer = 0.
- Resulting outputs: rsp_valid=0, busy=0, req_ready=0.
- Reset mid-operation discards all in-flight and buffered results; shifter outputs arriving afterwards are ignored.

Credits:
- credits = FIFO_DEPTH - fifo_count - inflight_count.
- An issue happens only when credits>0.
- A pop in the same cycle does not add a credit until the next cycle (registered count).

Arbitration:
- Round-robin.
- Search starts at (last_granted+1) mod NUM_REQ.
- The first requester with req_valid=1 gets req_ready=1, provided credits>0.
- All other req_ready=0.
- The pointer updates only on an actual issue.
- req_ready is combinational from req_valid and state; requesters must not derive req_valid from req_ready.

Issue:
- sh_opB, sh_sa and sh_op are driven combinationally from the granted requester.
- They are all-zero when nothing issues.
- {1, id, tag} enters stage 1 of a LATENCY-deep valid pipe; a bubble enters otherwise.
- Throughput is 1 op/cycle.

Completion:
- When pipe stage LATENCY is valid, {sh_result, id, tag} is written to the FIFO that cycle.
- Credits guarantee the FIFO is never full at a write.

Response:
- rsp_* present the FIFO head; rsp_valid = FIFO non-empty.
- Pop occurs on rsp_valid&rsp_ready.
- Simultaneous push and pop is legal; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- No bypass: minimum issue-to-rsp_valid latency is LATENCY+1 cycles.
- Results leave in issue order.

Other rules:
- busy = (inflight_count!=0) | (fifo_count!=0).
- No op is dropped or duplicated; every accepted op yields exactly one response.

Test Plan:
1. Single SLL: req0 opB=0x00000001, sa=4, op=00, tag=3 at cycle 0 -> sh_* match at cycle 0; rsp_valid at cycle 3 with result 0x00000010, id=0, tag=3.
2. SRA and SRL: opB=0x80000000, sa=4 -> op=11 gives 0xF8000000; op=01 gives 0x08000000; tags returned in order.
3. Round-robin: req0 and req1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 starting at 0 after reset; 1 op/cycle; responses alternate ids.
4. Backpressure: FIFO_DEPTH=4, rsp_ready=0, req0 always valid -> exactly 4 accepts, then req_ready=0. Raise rsp_ready -> 4 responses in order; issue resumes one cycle after the first pop; busy falls once all responses drain.
5. Reset mid-flight: issue 3 ops, assert reset for 1 cycle while 2 ops are in flight -> rsp_valid=0, busy=0; no stale responses ever appear; next op completes normally with tag intact.
6. Simultaneous push/pop at full occupancy minus one, with random rsp_ready -> scoreboard shows every accepted (id, tag, result) returned exactly once, in order.

Source files
------------

// File: rtl/vlane_shift_arbiter.sv
// vlane_shift_arbiter
//   Shares one pipelined vector-lane barrel shifter among NUM_REQ requesters.
//   Round-robin arbitration drives the shifter inputs, a LATENCY-deep valid
//   pipe tracks in-flight ops, and results land in a credit-protected FIFO so
//   downstream backpressure never drops a shifter result.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid/ready per-requester handshake (ready is a one-hot grant)
//   req_opB/sa/op/tag  packed per-requester operation fields
//   sh_opB/sa/op    to shifter (all-zero when nothing issues)
//   sh_result       from shifter, LATENCY cycles after issue
//   rsp_valid/ready response handshake at FIFO head
//   rsp_result/id/tag  head entry contents
//   busy            any op in flight or buffered
module vlane_shift_arbiter #(
    parameter int WIDTH      = 32,
    parameter int LOG2WIDTH  = 5,
    parameter int NUM_REQ    = 2,
    parameter int LOG2NUMREQ = 1,
    parameter int TAGW       = 4,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LOG2FIFO   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]      req_opB,
    input  logic [NUM_REQ*LOG2WIDTH-1:0]  req_sa,
    input  logic [NUM_REQ*2-1:0]          req_op,
    input  logic [NUM_REQ*TAGW-1:0]       req_tag,
    output logic [WIDTH-1:0]              sh_opB,
    output logic [LOG2WIDTH-1:0]          sh_sa,
    output logic [1:0]                    sh_op,
    input  logic [WIDTH-1:0]              sh_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WIDTH-1:0]              rsp_result,
    output logic [LOG2NUMREQ-1:0]         rsp_id,
    output logic [TAGW-1:0]               rsp_tag,
    output logic                          busy
);

    localparam int CNTW = LOG2FIFO + 1;
    localparam logic [CNTW:0]       DEPTH_L   = (CNTW+1)'(FIFO_DEPTH);
    localparam logic [LOG2FIFO-1:0] LAST_SLOT = LOG2FIFO'(FIFO_DEPTH - 1);

    // rr_ptr holds the index where the next search starts, i.e. last grant + 1.
    logic [LOG2NUMREQ-1:0] rr_ptr;
    logic [LOG2NUMREQ-1:0] scan_idx;
    logic [LOG2NUMREQ-1:0] grant_id;
    logic                  grant_found;
    logic                  has_credit;
    logic                  issue;

    logic [LATENCY-1:0]    pipe_v;
    logic [LOG2NUMREQ-1:0] pipe_id  [LATENCY];
    logic [TAGW-1:0]       pipe_tag [LATENCY];
    logic [CNTW-1:0]       inflight_count;

    logic [WIDTH-1:0]      mem_result [FIFO_DEPTH];
    logic [LOG2NUMREQ-1:0] mem_id     [FIFO_DEPTH];
    logic [TAGW-1:0]       mem_tag    [FIFO_DEPTH];
    logic [LOG2FIFO-1:0]   wr_ptr;
    logic [LOG2FIFO-1:0]   rd_ptr;
    logic [CNTW-1:0]       fifo_count;
    logic [CNTW:0]         occupancy;
    logic                  push;
    logic                  pop;

    // Round-robin search from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = LOG2NUMREQ'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    always_comb begin
        inflight_count = '0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
            inflight_count = inflight_count + CNTW'(pipe_v[k]);
        end
    end

    // Credits use registered counts only, so a pop frees a slot next cycle.
    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign has_credit = occupancy < DEPTH_L;
    assign issue      = grant_found & has_credit & ~reset;

    always_comb begin
        req_ready = '0;
        sh_opB    = '0;
        sh_sa     = '0;
        sh_op     = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            sh_opB = req_opB[32'(grant_id)*WIDTH +: WIDTH];
            sh_sa  = req_sa[32'(grant_id)*LOG2WIDTH +: LOG2WIDTH];
            sh_op  = req_op[32'(grant_id)*2 +: 2];
        end
    end

    // In-flight valid pipe; index 0 is stage 1, LATENCY-1 is the final stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_id[0]  <= grant_id;
        pipe_tag[0] <= req_tag[32'(grant_id)*TAGW +: TAGW];
        for (int unsigned k = 1; k < LATENCY; k++) begin
            pipe_id[k]  <= pipe_id[k-1];
            pipe_tag[k] <= pipe_tag[k-1];
        end
    end

    assign push = pipe_v[LATENCY-1];
    assign pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rr_ptr     <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
            if (issue) rr_ptr <= LOG2NUMREQ'((32'(grant_id) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= sh_result;
            mem_id[wr_ptr]     <= pipe_id[LATENCY-1];
            mem_tag[wr_ptr]    <= pipe_tag[LATENCY-1];
        end
    end

    assign rsp_valid  = (fifo_count != '0);
    assign rsp_result = mem_result[rd_ptr];
    assign rsp_id     = mem_id[rd_ptr];
    assign rsp_tag    = mem_tag[rd_ptr];
    assign busy       = (inflight_count != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_vlane_shift_arbiter.sv
module tb_vlane_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_opB;
    logic [9:0]  req_sa;
    logic [3:0]  req_op;
    logic [7:0]  req_tag;
    logic [31:0] sh_opB;
    logic [4:0]  sh_sa;
    logic [1:0]  sh_op;
    logic [31:0] sh_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [0:0]  rsp_id;
    logic [3:0]  rsp_tag;
    logic        busy;

    vlane_shift_arbiter #(
        .WIDTH(32), .LOG2WIDTH(5), .NUM_REQ(2), .LOG2NUMREQ(1),
        .TAGW(4), .LATENCY(2), .FIFO_DEPTH(4), .LOG2FIFO(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opB(req_opB), .req_sa(req_sa), .req_op(req_op), .req_tag(req_tag),
        .sh_opB(sh_opB), .sh_sa(sh_sa), .sh_op(sh_op), .sh_result(sh_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] shmod(input logic [31:0] b, input logic [4:0] sa,
                                          input logic [1:0] op);
        case (op)
            2'b01:   return b >> sa;
            2'b11:   return $unsigned($signed(b) >>> sa);
            default: return b << sa;
        endcase
    endfunction

    // External two-stage shifter model.
    logic [31:0] shs1, shs2;
    always @(posedge clk) begin
        shs1 <= shmod(sh_opB, sh_sa, sh_op);
        shs2 <= shs1;
    end
    assign sh_result = shs2;

    typedef struct packed {
        logic [0:0]  id;
        logic [3:0]  tag;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   accepts  = 0;
    int   pops     = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            if (rsp_valid && rsp_ready) begin
                pops++;
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL stale_rsp: got id %0h tag %0h result %0h expected no response",
                           rsp_id, rsp_tag, rsp_result);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_result", 64'(rsp_result), 64'(e.res));
                    check("sb_id",     64'(rsp_id),     64'(e.id));
                    check("sb_tag",    64'(rsp_tag),    64'(e.tag));
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id  = 1'(i);
                    e.tag = req_tag[i*4 +: 4];
                    e.res = shmod(req_opB[i*32 +: 32], req_sa[i*5 +: 5], req_op[i*2 +: 2]);
                    sb.push_back(e);
                    accepts++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] b, input logic [4:0] sa,
                           input logic [1:0] op, input logic [3:0] tag);
        req_opB[i*32 +: 32] = b;
        req_sa[i*5 +: 5]    = sa;
        req_op[i*2 +: 2]    = op;
        req_tag[i*4 +: 4]   = tag;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int acc0;
        reset     = 1'b1;
        req_valid = 2'b11;
        req_opB   = '0;
        req_sa    = '0;
        req_op    = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        tick();
        #1;
        check("ready_in_reset", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        // Single SLL, latency check.
        set_req(0, 32'h0000_0001, 5'd4, 2'b00, 4'd3);
        req_valid = 2'b01;
        #1;
        check("t1_sh_opB", 64'(sh_opB), 64'h1);
        check("t1_sh_sa", 64'(sh_sa), 64'd4);
        check("t1_sh_op", 64'(sh_op), 64'd0);
        check("t1_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        #1;
        check("t1_sh_idle", 64'(sh_opB), 64'd0);
        check("t1_c1_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t1_c1_busy", 64'(busy), 64'd1);
        tick();
        check("t1_c2_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("t1_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_result", 64'(rsp_result), 64'h10);
        check("t1_id", 64'(rsp_id), 64'd0);
        check("t1_tag", 64'(rsp_tag), 64'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_busy_after", 64'(busy), 64'd0);

        // SRA then SRL.
        rsp_ready = 1'b1;
        set_req(0, 32'h8000_0000, 5'd4, 2'b11, 4'd5);
        req_valid = 2'b01;
        tick();
        set_req(0, 32'h8000_0000, 5'd4, 2'b01, 4'd6);
        tick();
        req_valid = 2'b00;
        tick();
        check("t2_sra_valid", 64'(rsp_valid), 64'd1);
        check("t2_sra_result", 64'(rsp_result), 64'hF800_0000);
        check("t2_sra_tag", 64'(rsp_tag), 64'd5);
        tick();
        check("t2_srl_result", 64'(rsp_result), 64'h0800_0000);
        check("t2_srl_tag", 64'(rsp_tag), 64'd6);
        tick();
        check("t2_drained", 64'(rsp_valid), 64'd0);

        // Round-robin after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        acc0 = accepts;
        for (int c = 0; c < 8; c++) begin
            set_req(0, $urandom, 5'($urandom_range(0, 31)), 2'b00, 4'(c));
            set_req(1, $urandom, 5'($urandom_range(0, 31)), 2'b11, 4'(c + 8));
            #1;
            check("t3_rr_grant", 64'(req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
            tick();
        end
        req_valid = 2'b00;
        check("t3_accepts", 64'(accepts - acc0), 64'd8);
        wait_idle();

        // Backpressure fills the FIFO to exactly FIFO_DEPTH.
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        acc0 = accepts;
        for (int c = 0; c < 8; c++) begin
            set_req(0, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 1)), 4'(c));
            tick();
        end
        check("t4_accepts", 64'(accepts - acc0), 64'd4);
        check("t4_ready_full", 64'(req_ready), 64'd0);
        check("t4_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        #1;
        check("t4_ready_same_cycle_pop", 64'(req_ready), 64'd0);
        tick();
        check("t4_ready_resume", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        wait_idle();

        // Reset with ops in flight.
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, 32'hA5A5_0F0F, 5'd1, 2'b00, 4'd1);
        tick();
        set_req(0, 32'hA5A5_0F0F, 5'd2, 2'b01, 4'd2);
        tick();
        set_req(0, 32'hA5A5_0F0F, 5'd3, 2'b11, 4'd4);
        tick();
        req_valid = 2'b00;
        check("t5_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t5_no_stale", 64'(rsp_valid), 64'd0);
        end
        set_req(0, 32'h1234_5678, 5'd8, 2'b01, 4'd9);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check("t5_new_valid", 64'(rsp_valid), 64'd1);
        check("t5_new_result", 64'(rsp_result), 64'h0012_3456);
        check("t5_new_tag", 64'(rsp_tag), 64'd9);
        check("t5_new_id", 64'(rsp_id), 64'd0);
        tick();
        wait_idle();

        // Random traffic with random backpressure.
        acc0 = accepts - pops;
        for (int c = 0; c < 300; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                set_req(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        wait_idle();
        check("t6_conservation", 64'(accepts - pops), 64'(acc0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
